// File: rtl/digit_lock_ctrl.sv
// digit_lock_ctrl: ASCII digit-code lock fed by a UART receiver byte strobe.
// Verifies a CODE_LEN-digit code and raises auth. Repeated wrong codes lead
// to a timed lockout. A partial entry is discarded after an idle gap. The
// code can be reprogrammed while unlocked.
module digit_lock_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [8*CODE_LEN-1:0] DEFAULT_CODE   = "1416",
  parameter int                    MAX_TRIES      = 3,
  parameter int                    LOCKOUT_CYCLES = 100_000_000,
  parameter int                    IDLE_TIMEOUT   = 50_000_000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_done,
  output logic                            auth,
  output logic                            locked_out,
  output logic                            fail_pulse,
  output logic                            prog_done,
  output logic                            prog_mode,
  output logic [$clog2(CODE_LEN+1)-1:0]   entry_cnt
);

  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam int BW = 8 * CODE_LEN;

  localparam logic [CW-1:0] LAST_DIGIT = CW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

  localparam logic [7:0] CH_CLEAR   = 8'h2A;  // '*'
  localparam logic [7:0] CH_RELOCK  = 8'h4C;  // 'L'
  localparam logic [7:0] CH_PROGRAM = 8'h50;  // 'P'

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_UNLOCKED,
    ST_PROGRAM,
    ST_LOCKOUT
  } state_t;

  state_t        state, state_d;
  logic [BW-1:0] entry_buf, entry_buf_d;
  logic [CW-1:0] entry_cnt_d;
  logic [FW-1:0] fail_cnt, fail_cnt_d;
  logic [BW-1:0] code_reg, code_d;
  logic [IW-1:0] idle_cnt, idle_cnt_d;
  logic [LW-1:0] lock_tmr, lock_tmr_d;
  logic          fail_pulse_d, prog_done_d;

  logic          is_digit, is_clear, is_relock, is_program;
  logic          last_digit, idle_active, idle_expire;
  logic [BW-1:0] shifted;
  logic [FW-1:0] fail_next;

  // Byte classification and the candidate code with the new digit appended.
  always_comb begin
    is_digit    = rx_done && (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_clear    = rx_done && (rx_data == CH_CLEAR);
    is_relock   = rx_done && (rx_data == CH_RELOCK);
    is_program  = rx_done && (rx_data == CH_PROGRAM);
    last_digit  = (entry_cnt == LAST_DIGIT);
    shifted     = (entry_buf << 8) | BW'(rx_data);
    fail_next   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
    idle_active = ((state == ST_LOCKED) || (state == ST_PROGRAM)) && (entry_cnt != '0);
    // A strobe in the expiry cycle takes priority over the timeout.
    idle_expire = idle_active && !rx_done && (idle_cnt == IDLE_LAST);
  end

  // Next-state and next-register logic for the whole controller.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d      = state;
    entry_buf_d  = entry_buf;
    entry_cnt_d  = entry_cnt;
    fail_cnt_d   = fail_cnt;
    code_d       = code_reg;
    lock_tmr_d   = lock_tmr;
    fail_pulse_d = 1'b0;
    prog_done_d  = 1'b0;
    idle_cnt_d   = (idle_active && !rx_done && !idle_expire) ? idle_cnt + 1'b1 : '0;

    unique case (state)
      ST_LOCKED: begin
        if (is_digit) begin
          if (last_digit) begin
            entry_buf_d = '0;
            entry_cnt_d = '0;
            if (shifted == code_reg) begin
              state_d    = ST_UNLOCKED;
              fail_cnt_d = '0;
            end else begin
              fail_pulse_d = 1'b1;
              fail_cnt_d   = fail_next;
              if (fail_next == FAIL_MAX) begin
                state_d    = ST_LOCKOUT;
                lock_tmr_d = LOCK_LOAD;
              end
            end
          end else begin
            entry_buf_d = shifted;
            entry_cnt_d = entry_cnt + 1'b1;
          end
        end else if (is_clear || idle_expire) begin
          entry_buf_d = '0;
          entry_cnt_d = '0;
        end
      end

      ST_UNLOCKED: begin
        if (is_relock) begin
          state_d = ST_LOCKED;
        end else if (is_program) begin
          state_d = ST_PROGRAM;
        end
      end

      ST_PROGRAM: begin
        if (is_digit) begin
          if (last_digit) begin
            code_d      = shifted;
            prog_done_d = 1'b1;
            state_d     = ST_UNLOCKED;
            entry_buf_d = '0;
            entry_cnt_d = '0;
          end else begin
            entry_buf_d = shifted;
            entry_cnt_d = entry_cnt + 1'b1;
          end
        end else if (is_clear || idle_expire) begin
          state_d     = ST_UNLOCKED;
          entry_buf_d = '0;
          entry_cnt_d = '0;
        end
      end

      ST_LOCKOUT: begin
        entry_buf_d = '0;
        entry_cnt_d = '0;
        if (lock_tmr == '0) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = '0;
        end else begin
          lock_tmr_d = lock_tmr - 1'b1;
        end
      end

      default: state_d = ST_LOCKED;
    endcase
  end

  // State and datapath registers; reset aborts any entry, program or lockout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_LOCKED;
      entry_buf  <= '0;
      entry_cnt  <= '0;
      fail_cnt   <= '0;
      // NOTE: the code register is a few flops, not a RAM, so it takes a reset value.
      code_reg   <= DEFAULT_CODE;
      idle_cnt   <= '0;
      lock_tmr   <= '0;
      fail_pulse <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating on the same edge.
      state      <= state_d;
      entry_buf  <= entry_buf_d;
      entry_cnt  <= entry_cnt_d;
      fail_cnt   <= fail_cnt_d;
      code_reg   <= code_d;
      idle_cnt   <= idle_cnt_d;
      lock_tmr   <= lock_tmr_d;
      fail_pulse <= fail_pulse_d;
      prog_done  <= prog_done_d;
    end
  end

  assign auth       = (state == ST_UNLOCKED) || (state == ST_PROGRAM);
  assign prog_mode  = (state == ST_PROGRAM);
  assign locked_out = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_digit_lock_ctrl.sv
// tb_digit_lock_ctrl: table-driven vectors plus directed multi-cycle sequences.
module tb_digit_lock_ctrl;

  localparam int LOCK_CYC = 20;
  localparam int IDLE_CYC = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       auth, locked_out, fail_pulse, prog_done, prog_mode;
  logic [2:0] entry_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fail_seen = 0;

  digit_lock_ctrl #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   ("1416"),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (LOCK_CYC),
    .IDLE_TIMEOUT   (IDLE_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .auth       (auth),
    .locked_out (locked_out),
    .fail_pulse (fail_pulse),
    .prog_done  (prog_done),
    .prog_mode  (prog_mode),
    .entry_cnt  (entry_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter and fail pulse tally, sampled at the active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fail_pulse === 1'b1) fail_seen <= fail_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic [7:0] exp;  // {auth, locked_out, fail_pulse, prog_done, prog_mode, entry_cnt}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] d, input logic s, input logic a,
                              input logic l, input logic f, input logic p,
                              input logic m, input logic [2:0] c);
    vec_t v;
    v.d   = d;
    v.s   = s;
    v.exp = {a, l, f, p, m, c};
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] obs();
    return {auth, locked_out, fail_pulse, prog_done, prog_mode, entry_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check("reset_outputs", {24'h0, obs()}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0, g, f0;
    reset_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;

    // Ignored bytes, correct code, programming, wrong code, clear and abort.
    add("L", 1, 0,0,0,0,0, 0);
    add("P", 1, 0,0,0,0,0, 0);
    add("A", 1, 0,0,0,0,0, 0);
    add("1", 1, 0,0,0,0,0, 1);
    add("5", 0, 0,0,0,0,0, 1);
    add("4", 1, 0,0,0,0,0, 2);
    add("1", 1, 0,0,0,0,0, 3);
    add("6", 1, 1,0,0,0,0, 0);
    add("L", 0, 1,0,0,0,0, 0);
    add("Z", 1, 1,0,0,0,0, 0);
    add("P", 1, 1,0,0,0,1, 0);
    add("2", 1, 1,0,0,0,1, 1);
    add("4", 1, 1,0,0,0,1, 2);
    add("6", 1, 1,0,0,0,1, 3);
    add("8", 1, 1,0,0,1,0, 0);
    add("0", 0, 1,0,0,0,0, 0);
    add("L", 1, 0,0,0,0,0, 0);
    add("1", 1, 0,0,0,0,0, 1);
    add("4", 1, 0,0,0,0,0, 2);
    add("1", 1, 0,0,0,0,0, 3);
    add("6", 1, 0,0,1,0,0, 0);
    add("0", 0, 0,0,0,0,0, 0);
    add("2", 1, 0,0,0,0,0, 1);
    add("4", 1, 0,0,0,0,0, 2);
    add("6", 1, 0,0,0,0,0, 3);
    add("8", 1, 1,0,0,0,0, 0);
    add("P", 1, 1,0,0,0,1, 0);
    add("1", 1, 1,0,0,0,1, 1);
    add("4", 1, 1,0,0,0,1, 2);
    add("1", 1, 1,0,0,0,1, 3);
    add("6", 1, 1,0,0,1,0, 0);
    add("L", 1, 0,0,0,0,0, 0);
    add("1", 1, 0,0,0,0,0, 1);
    add("4", 1, 0,0,0,0,0, 2);
    add("*", 1, 0,0,0,0,0, 0);
    add("1", 1, 0,0,0,0,0, 1);
    add("4", 1, 0,0,0,0,0, 2);
    add("1", 1, 0,0,0,0,0, 3);
    add("6", 1, 1,0,0,0,0, 0);
    add("P", 1, 1,0,0,0,1, 0);
    add("1", 1, 1,0,0,0,1, 1);
    add("2", 1, 1,0,0,0,1, 2);
    add("*", 1, 1,0,0,0,0, 0);
    add("L", 1, 0,0,0,0,0, 0);
    add("1", 1, 0,0,0,0,0, 1);
    add("4", 1, 0,0,0,0,0, 2);
    add("1", 1, 0,0,0,0,0, 3);
    add("6", 1, 1,0,0,0,0, 0);
    add("L", 1, 0,0,0,0,0, 0);

    repeat (2) @(negedge clk);
    check("reset_state", {24'h0, obs()}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rx_data = vecs[i].d;
      rx_done = vecs[i].s;
      @(negedge clk);
      check($sformatf("vec%0d", i), {24'h0, obs()}, {24'h0, vecs[i].exp});
    end
    rx_done = 1'b0;
    rx_data = 8'h00;

    // Three wrong codes lead to lockout; digits are ignored during it.
    for (int k = 1; k <= 3; k++) begin
      send_str("0000");
      check($sformatf("wrong%0d_fail_pulse", k), fail_pulse, 1'b1);
      check($sformatf("wrong%0d_locked_out", k), locked_out, (k == 3));
    end
    t0 = cyc;
    send_str("1416");
    check("lockout_ignores_auth", auth, 1'b0);
    check("lockout_ignores_cnt", entry_cnt, 3'd0);
    check("lockout_still_on", locked_out, 1'b1);
    g = 0;
    while (locked_out === 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("lockout_ends", (g < 1000), 1'b1);
    check("lockout_length", cyc - t0, LOCK_CYC);
    // Fail count restarts after lockout: two more wrong codes do not lock.
    send_str("0000");
    send_str("0000");
    check("post_lockout_no_relock", locked_out, 1'b0);
    send_str("1416");
    check("post_lockout_unlock", auth, 1'b1);
    send("L");

    // Idle timeout discards a partial entry at exactly IDLE_CYC quiet cycles.
    f0 = fail_seen;
    send_str("14");
    wait_cyc(IDLE_CYC - 1);
    check("idle_before_expiry", entry_cnt, 3'd2);
    wait_cyc(1);
    check("idle_expired", entry_cnt, 3'd0);
    // A strobe in the expiry cycle is processed and restarts the counter.
    send("1");
    wait_cyc(IDLE_CYC - 1);
    send("4");
    check("idle_strobe_wins", entry_cnt, 3'd2);
    wait_cyc(IDLE_CYC - 1);
    check("idle_restarted", entry_cnt, 3'd2);
    wait_cyc(1);
    check("idle_expired_again", entry_cnt, 3'd0);
    wait_cyc(2);
    check("idle_no_fail", fail_seen - f0, 0);
    send_str("1416");
    check("idle_then_unlock", auth, 1'b1);
    // Idle timeout in PROGRAM aborts back to UNLOCKED without storing.
    send_str("P12");
    wait_cyc(IDLE_CYC);
    check("prog_idle_abort_mode", prog_mode, 1'b0);
    check("prog_idle_abort_auth", auth, 1'b1);
    send("L");
    send_str("1416");
    check("prog_idle_code_kept", auth, 1'b1);
    send("L");

    // Reset mid-entry: a lone trailing digit must not complete the code.
    send_str("141");
    pulse_reset();
    send("6");
    check("reset_entry_aborted_auth", auth, 1'b0);
    check("reset_entry_aborted_cnt", entry_cnt, 3'd1);
    send("*");
    send_str("1416");
    check("reset_then_unlock", auth, 1'b1);
    // Reset mid-program leaves the default code in place.
    send_str("P999");
    pulse_reset();
    send_str("1416");
    check("reset_program_code_kept", auth, 1'b1);
    send("L");
    // Reset mid-lockout clears the lockout immediately.
    send_str("000000000000");
    check("lockout_before_reset", locked_out, 1'b1);
    pulse_reset();
    send_str("1416");
    check("reset_lockout_unlock", auth, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
